bbox_msg_reader: RTL and testbench
==================================

Name: bbox_msg_reader

Overview:
- Memory-mapped initiator that drains red-bounding-box messages from the image-processor message FIFO over its 3-bit-address, 32-bit, fixed-latency slave port.
- Polls the status register and reads three-word "RBB" messages (ID, top-left, bottom-right).
- Decodes each message into a registered bounding box with a one-cycle valid strobe for downstream rover control logic.
- Re-synchronises by flushing the FIFO when a corrupt or misaligned message is detected.

Parameters:
- POLL_GAP, 16, idle cycles between status polls when fewer than 3 words are buffered.
- READ_LATENCY, 1, cycles from read strobe to readdata valid; fixed slave latency.
- MSG_ID, 32'h00524242, expected header word ("RBB").
- IMAGE_W, 640, frame width used for the empty-box check.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, the FSM finishes its current message and then parks in IDLE.
- m_chipselect  out  1  slave select; asserted together with m_read or m_write.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_address  out  3  0=status, 1=message, 2=ID, 3=bbox colour.
- m_writedata  out  32  write data; only used for flush (32'h10).
- m_readdata  in  32  slave read data.
- bb_valid  out  1  one-cycle pulse when a new box is published.
- bb_left, bb_top, bb_right, bb_bottom  out  11 each  decoded box.
- bb_empty  out  1  box describes no red pixels (left > right).
- msg_count  out  16  messages accepted, saturating.
- err_count  out  8  resyncs performed, saturating.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-transaction aborts the transaction immediately with no partial publish.
- Read transaction: m_chipselect and m_read are high for exactly 1 cycle. m_readdata is sampled READ_LATENCY cycles later.
- Read spacing: m_read is always low for at least 1 cycle between reads. The slave pops its FIFO on a read rising edge, so back-to-back reads are forbidden.
- Write transaction: m_chipselect and m_write are high for exactly 1 cycle; m_read is never asserted at the same time.
- FSM states: IDLE, RD_STAT, WT_STAT, RD_ID, WT_ID, RD_TL, WT_TL, RD_BR, WT_BR, PUBLISH, FLUSH, GAP.
- IDLE -> RD_STAT when enable=1.
- WT_STAT: words = readdata[15:8]. If words >= 3 -> RD_ID; otherwise -> GAP.
- GAP: counts POLL_GAP cycles, then -> IDLE.
- WT_ID: data == MSG_ID -> RD_TL; otherwise -> FLUSH.
- WT_TL and WT_BR: each word is laid out as {5'b0, x[10:0], 5'b0, y[10:0]}. Capture x = word[26:15+1], i.e. [26:16], and y = word[10:0].
  - Nonzero pad bits [31:27] or [15:11] -> FLUSH.
  - x > IMAGE_W-1 -> FLUSH.
- PUBLISH: register all four edges, pulse bb_valid for 1 cycle, set bb_empty = (left > right), increment msg_count, -> IDLE.
- Between messages, bb_* holds the last published value.
- FLUSH: write 32'h10 to address 0, increment err_count, -> GAP. No box is published for a flushed message.
- Message latency: 7 cycles from RD_ID entry to the bb_valid pulse (3 reads x 2 cycles + PUBLISH).
- enable deasserted mid-message: the message completes and publishes. The enable check happens only in IDLE.
- Counters saturate at all-ones; they do not wrap.
- Status word with words = 255 (FIFO full) is treated as the normal words >= 3 path.

Decomposition:
- Shared package holds:
  - register addresses (STATUS=0, MSG=1, ID=2, BBCOL=3);
  - flush bit index 4 and the FLUSH_WORD constant;
  - MSG_ID;
  - the coordinate field slice constants;
  - the FSM state enum.
- One sub-module, mm_read_engine, owns single-read/single-write sequencing: it issues the strobe, waits READ_LATENCY, returns data with a done pulse, and enforces the idle gap.
- The top level holds the message FSM, decode, and counters.

Test Plan:
- Status readdata = 32'h0000_0300, then 32'h00524242, 32'h0064_0032, 32'h00C8_0096 -> bb_valid pulse with left=100, top=50, right=200, bottom=150, bb_empty=0, msg_count=1.
- Status words = 2 repeatedly -> no m_read to address 1, polls spaced POLL_GAP+2 cycles apart, bb_valid stays 0.
- ID word = 32'h00001234 -> one write with m_address=0 and m_writedata=32'h10, err_count=1, no bb_valid, next poll after the gap.
- Message words 32'h027F_01DF then 32'h0000_0000 -> bb_empty=1 with left=639, top=479, right=0, bottom=0.
- Over any traffic, m_read is never high on two consecutive cycles; assert m_read & m_write never both high.
- Reset asserted during WT_TL -> all outputs 0 immediately; after release, the first bus activity is a status read and no stale box is published.

Source files
------------

// File: rtl/bbox_msg_reader_pkg.sv
// Shared constants and state encodings for the red-bounding-box message reader.
// Holds slave register map, flush command word, RBB header, field slices, FSM enums.
package bbox_msg_reader_pkg;

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_MSG    = 3'd1;
    localparam logic [2:0] ADDR_ID     = 3'd2;
    localparam logic [2:0] ADDR_BBCOL  = 3'd3;

    localparam int          FLUSH_BIT  = 4;
    localparam logic [31:0] FLUSH_WORD = 32'h1 << FLUSH_BIT;

    localparam logic [31:0] MSG_ID_RBB = 32'h0052_4242;

    // Status word: buffered word count
    localparam int WORDS_LSB = 8;
    localparam int WORDS_MSB = 15;

    // Coordinate word: {5'b0, x[10:0], 5'b0, y[10:0]}
    localparam int X_LSB    = 16;
    localparam int X_MSB    = 26;
    localparam int Y_LSB    = 0;
    localparam int Y_MSB    = 10;
    localparam int PADH_LSB = 27;
    localparam int PADH_MSB = 31;
    localparam int PADL_LSB = 11;
    localparam int PADL_MSB = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_STAT,
        S_WT_STAT,
        S_RD_ID,
        S_WT_ID,
        S_RD_TL,
        S_WT_TL,
        S_RD_BR,
        S_WT_BR,
        S_PUBLISH,
        S_FLUSH,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_WAIT,
        E_WGAP
    } eng_state_t;

    function automatic logic coord_pad_ok(input logic [31:0] w);
        return (w[PADH_MSB:PADH_LSB] == '0) && (w[PADL_MSB:PADL_LSB] == '0);
    endfunction

endpackage

// File: rtl/bbox_msg_reader_mm_read_engine.sv
// Single-access bus sequencer: one-cycle read/write strobes, fixed-latency read return.
// Ports: i_rd_req/i_wr_req/i_addr/i_wdata request side; o_ready/o_done/o_rdata; m_* bus side.
module mm_read_engine
    import bbox_msg_reader_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_rd_req,
    input  logic        i_wr_req,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_m_chipselect,
    output logic        o_m_read,
    output logic        o_m_write,
    output logic [2:0]  o_m_address,
    output logic [31:0] o_m_writedata,
    input  logic [31:0] i_m_readdata
);

    localparam int         LW       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

    eng_state_t      r_state;
    eng_state_t      w_next;
    logic [LW-1:0]   r_lat;

    assign o_rdata = i_m_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= E_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat <= '0;
        end else if (r_state == E_WAIT) begin
            r_lat <= r_lat + LW'(1);
        end else begin
            r_lat <= '0;
        end
    end

    // The strobe is issued from E_IDLE only and is always followed by
    // E_WAIT or E_WGAP, so two strobes can never be adjacent.
    always_comb begin
        w_next         = r_state;
        o_ready        = 1'b0;
        o_done         = 1'b0;
        o_m_chipselect = 1'b0;
        o_m_read       = 1'b0;
        o_m_write      = 1'b0;
        o_m_address    = 3'd0;
        o_m_writedata  = 32'd0;
        unique case (r_state)
            E_IDLE: begin
                o_ready = 1'b1;
                if (i_rd_req) begin
                    o_m_chipselect = 1'b1;
                    o_m_read       = 1'b1;
                    o_m_address    = i_addr;
                    w_next         = E_WAIT;
                end else if (i_wr_req) begin
                    o_m_chipselect = 1'b1;
                    o_m_write      = 1'b1;
                    o_m_address    = i_addr;
                    o_m_writedata  = i_wdata;
                    w_next         = E_WGAP;
                end
            end
            E_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    o_done = 1'b1;
                    w_next = E_IDLE;
                end
            end
            E_WGAP: begin
                w_next = E_IDLE;
            end
            default: begin
                w_next = E_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bbox_msg_reader.sv
// Drains RBB messages from the image-processor FIFO and publishes decoded boxes.
// Ports: clk/reset/enable; m_* slave bus; bb_* decoded box + valid pulse; msg/err counters.
module bbox_msg_reader
    import bbox_msg_reader_pkg::*;
#(
    parameter int          POLL_GAP     = 16,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] MSG_ID       = MSG_ID_RBB,
    parameter int          IMAGE_W      = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        bb_valid,
    output logic [10:0] bb_left,
    output logic [10:0] bb_top,
    output logic [10:0] bb_right,
    output logic [10:0] bb_bottom,
    output logic        bb_empty,
    output logic [15:0] msg_count,
    output logic [7:0]  err_count
);

    localparam int          GW       = $clog2(POLL_GAP + 1);
    // GAP plus the following IDLE cycle give POLL_GAP bus-idle cycles.
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 2);
    localparam logic [10:0] X_MAX    = 11'(IMAGE_W - 1);

    state_t         r_state;
    state_t         w_next;
    logic [GW-1:0]  r_gap_cnt;

    logic           w_rd_req;
    logic           w_wr_req;
    logic [2:0]     w_addr;
    logic [31:0]    w_wdata;
    logic           w_eng_ready;
    logic           w_eng_done;
    logic [31:0]    w_eng_rdata;

    logic [7:0]     w_words;
    logic [10:0]    w_x;
    logic [10:0]    w_y;
    logic           w_coord_ok;

    logic [10:0]    r_tl_x;
    logic [10:0]    r_tl_y;
    logic [10:0]    r_br_x;
    logic [10:0]    r_br_y;

    logic           r_bb_valid;
    logic [10:0]    r_bb_left;
    logic [10:0]    r_bb_top;
    logic [10:0]    r_bb_right;
    logic [10:0]    r_bb_bottom;
    logic           r_bb_empty;
    logic [15:0]    r_msg_count;
    logic [7:0]     r_err_count;

    assign bb_valid  = r_bb_valid;
    assign bb_left   = r_bb_left;
    assign bb_top    = r_bb_top;
    assign bb_right  = r_bb_right;
    assign bb_bottom = r_bb_bottom;
    assign bb_empty  = r_bb_empty;
    assign msg_count = r_msg_count;
    assign err_count = r_err_count;

    mm_read_engine #(
        .READ_LATENCY (READ_LATENCY)
    ) u_eng (
        .clk            (clk),
        .reset          (reset),
        .i_rd_req       (w_rd_req),
        .i_wr_req       (w_wr_req),
        .i_addr         (w_addr),
        .i_wdata        (w_wdata),
        .o_ready        (w_eng_ready),
        .o_done         (w_eng_done),
        .o_rdata        (w_eng_rdata),
        .o_m_chipselect (m_chipselect),
        .o_m_read       (m_read),
        .o_m_write      (m_write),
        .o_m_address    (m_address),
        .o_m_writedata  (m_writedata),
        .i_m_readdata   (m_readdata)
    );

    assign w_words    = w_eng_rdata[WORDS_MSB:WORDS_LSB];
    assign w_x        = w_eng_rdata[X_MSB:X_LSB];
    assign w_y        = w_eng_rdata[Y_MSB:Y_LSB];
    assign w_coord_ok = coord_pad_ok(w_eng_rdata) && (w_x <= X_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_rd_req = 1'b0;
        w_wr_req = 1'b0;
        w_addr   = ADDR_STATUS;
        w_wdata  = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                if (enable) w_next = S_RD_STAT;
            end
            S_RD_STAT: begin
                w_rd_req = 1'b1;
                w_addr   = ADDR_STATUS;
                if (w_eng_ready) w_next = S_WT_STAT;
            end
            S_WT_STAT: begin
                if (w_eng_done) begin
                    w_next = (w_words >= 8'd3) ? S_RD_ID : S_GAP;
                end
            end
            S_RD_ID: begin
                w_rd_req = 1'b1;
                w_addr   = ADDR_MSG;
                if (w_eng_ready) w_next = S_WT_ID;
            end
            S_WT_ID: begin
                if (w_eng_done) begin
                    w_next = (w_eng_rdata == MSG_ID) ? S_RD_TL : S_FLUSH;
                end
            end
            S_RD_TL: begin
                w_rd_req = 1'b1;
                w_addr   = ADDR_MSG;
                if (w_eng_ready) w_next = S_WT_TL;
            end
            S_WT_TL: begin
                if (w_eng_done) begin
                    w_next = w_coord_ok ? S_RD_BR : S_FLUSH;
                end
            end
            S_RD_BR: begin
                w_rd_req = 1'b1;
                w_addr   = ADDR_MSG;
                if (w_eng_ready) w_next = S_WT_BR;
            end
            S_WT_BR: begin
                if (w_eng_done) begin
                    w_next = w_coord_ok ? S_PUBLISH : S_FLUSH;
                end
            end
            S_PUBLISH: begin
                w_next = S_IDLE;
            end
            S_FLUSH: begin
                w_wr_req = 1'b1;
                w_addr   = ADDR_STATUS;
                w_wdata  = FLUSH_WORD;
                if (w_eng_ready) w_next = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap_cnt   <= '0;
            r_tl_x      <= '0;
            r_tl_y      <= '0;
            r_br_x      <= '0;
            r_br_y      <= '0;
            r_bb_valid  <= 1'b0;
            r_bb_left   <= '0;
            r_bb_top    <= '0;
            r_bb_right  <= '0;
            r_bb_bottom <= '0;
            r_bb_empty  <= 1'b0;
            r_msg_count <= '0;
            r_err_count <= '0;
        end else begin
            r_bb_valid <= 1'b0;

            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end

            if (r_state == S_WT_TL && w_eng_done) begin
                r_tl_x <= w_x;
                r_tl_y <= w_y;
            end

            if (r_state == S_WT_BR && w_eng_done) begin
                r_br_x <= w_x;
                r_br_y <= w_y;
            end

            if (r_state == S_PUBLISH) begin
                r_bb_valid  <= 1'b1;
                r_bb_left   <= r_tl_x;
                r_bb_top    <= r_tl_y;
                r_bb_right  <= r_br_x;
                r_bb_bottom <= r_br_y;
                r_bb_empty  <= (r_tl_x > r_br_x);
                if (r_msg_count != '1) begin
                    r_msg_count <= r_msg_count + 16'd1;
                end
            end

            if (r_state == S_FLUSH && w_eng_ready && r_err_count != '1) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Self-checking bench for bbox_msg_reader with a FIFO slave model.
// Expected boxes and counters come from the message rules applied to the words pushed.
module tb_bbox_msg_reader;

    localparam int          POLL_GAP = 16;
    localparam int          IMAGE_W  = 640;
    localparam logic [31:0] RBB      = 32'h0052_4242;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        bb_valid;
    logic [10:0] bb_left;
    logic [10:0] bb_top;
    logic [10:0] bb_right;
    logic [10:0] bb_bottom;
    logic        bb_empty;
    logic [15:0] msg_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    bbox_msg_reader #(
        .POLL_GAP     (POLL_GAP),
        .READ_LATENCY (1),
        .MSG_ID       (RBB),
        .IMAGE_W      (IMAGE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .bb_valid     (bb_valid),
        .bb_left      (bb_left),
        .bb_top       (bb_top),
        .bb_right     (bb_right),
        .bb_bottom    (bb_bottom),
        .bb_empty     (bb_empty),
        .msg_count    (msg_count),
        .err_count    (err_count)
    );

    typedef struct {
        logic [10:0] l;
        logic [10:0] t;
        logic [10:0] r;
        logic [10:0] b;
        logic        e;
    } box_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_valid = 0;
    int          n_wr = 0;
    int          last_valid_cyc = 0;
    int          last_wr_cyc = 0;
    int          exp_msg = 0;
    int          exp_err = 0;
    logic        prev_rd = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] fifo[$];
    box_t        exp_q[$];
    int          rd_cyc[$];
    logic [2:0]  rd_adr[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO slave: one-cycle read latency, pop on message read, flush on bit 4 write.
    always @(posedge clk) begin
        if (m_chipselect && m_read) begin
            if (m_address == 3'd0) begin
                m_readdata <= {16'h0, (fifo.size() > 255) ? 8'd255 : 8'(fifo.size()), 8'h0};
            end else if (m_address == 3'd1 && fifo.size() > 0) begin
                m_readdata <= fifo.pop_front();
            end else begin
                m_readdata <= 32'h0;
            end
        end
        if (m_chipselect && m_write && m_address == 3'd0 && m_writedata[4]) begin
            fifo.delete();
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (m_read) chk("b2b_read", {63'd0, prev_rd}, 64'd0);
            if (m_read || m_write) chk("rd_and_wr", {63'd0, m_read & m_write}, 64'd0);
            if (m_chipselect || m_read || m_write) begin
                chk("cs_pairing", {63'd0, m_chipselect}, {63'd0, m_read | m_write});
            end
            if (m_chipselect && m_read) begin
                rd_cyc.push_back(cyc);
                rd_adr.push_back(m_address);
            end
            if (m_chipselect && m_write) begin
                n_wr++;
                last_wr_cyc = cyc;
                chk("flush_write", {29'd0, m_address, m_writedata}, {29'd0, 3'd0, 32'h10});
            end
            if (bb_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                chk("valid_width", {63'd0, prev_valid}, 64'd0);
                chk("valid_expected", {63'd0, exp_q.size() > 0}, 64'd1);
                if (exp_q.size() > 0) begin
                    box_t e;
                    e = exp_q.pop_front();
                    chk("box", {19'd0, bb_left, bb_top, bb_right, bb_bottom, bb_empty},
                        {19'd0, e.l, e.t, e.r, e.b, e.e});
                end
            end
        end
        prev_rd    = m_read;
        prev_valid = bb_valid;
    end

    function automatic bit word_ok(input logic [31:0] w);
        logic [10:0] x;
        x = w[26:16];
        return (w[31:27] == 5'd0) && (w[15:11] == 5'd0) && (int'(x) < IMAGE_W);
    endfunction

    task automatic push_msg(input logic [31:0] id, input logic [31:0] tl,
                            input logic [31:0] br);
        box_t b;
        logic [10:0] l;
        logic [10:0] r;
        if (id == RBB && word_ok(tl) && word_ok(br)) begin
            l   = tl[26:16];
            r   = br[26:16];
            b.l = l;
            b.t = tl[10:0];
            b.r = r;
            b.b = br[10:0];
            b.e = (l > r);
            exp_q.push_back(b);
            exp_msg = (exp_msg == 65535) ? 65535 : exp_msg + 1;
        end else begin
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        end
        fifo.push_back(id);
        fifo.push_back(tl);
        fifo.push_back(br);
    endtask

    task automatic rand_msg(output logic [31:0] id, output logic [31:0] tl,
                            output logic [31:0] br);
        logic [10:0] x1;
        logic [10:0] x2;
        int p;
        x1 = 11'($urandom_range(0, IMAGE_W - 1));
        x2 = 11'($urandom_range(0, IMAGE_W - 1));
        id = RBB;
        tl = {5'd0, x1, 5'd0, 11'($urandom_range(0, 2047))};
        br = {5'd0, x2, 5'd0, 11'($urandom_range(0, 2047))};
        case ($urandom_range(0, 5))
            3: id = $urandom;
            4: begin
                p = $urandom_range(0, 9);
                if (p < 5) tl = tl | (32'h1 << (27 + p));
                else br = br | (32'h1 << (11 + p - 5));
            end
            5: br[26:16] = 11'($urandom_range(IMAGE_W, 2047));
            default: ;
        endcase
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_drain"}, 64'(k < 5000), 64'd1);
        repeat (POLL_GAP * 2 + 8) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_msg_count"}, 64'(msg_count), 64'(exp_msg));
        chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
    endtask

    task automatic wait_msg_reads(input int n, input string tag);
        int seen;
        int k;
        seen = 0;
        k = 0;
        while (seen < n && k < 400) begin
            @(negedge clk);
            if (m_chipselect && m_read && m_address == 3'd1) seen++;
            k++;
        end
        chk({tag, "_msg_reads"}, 64'(seen), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus"}, {26'd0, m_chipselect, m_read, m_write, m_address, m_writedata}, 64'd0);
        chk({tag, "_box"}, {18'd0, bb_valid, bb_left, bb_top, bb_right, bb_bottom, bb_empty}, 64'd0);
        chk({tag, "_cnt"}, {40'd0, msg_count, err_count}, 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout exp finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int idx;
        int np;
        int nmsg;
        int last;
        int vmark;
        int k;
        logic [31:0] id;
        logic [31:0] tl;
        logic [31:0] br;

        reset      = 1'b1;
        enable     = 1'b0;
        m_readdata = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Parked with enable low
        repeat (2 * POLL_GAP) @(negedge clk);
        chk("park_no_reads", 64'(rd_cyc.size()), 64'd0);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Basic message
        mark = rd_adr.size();
        push_msg(RBB, 32'h0064_0032, 32'h00C8_0096);
        wait_drain("t1");
        chk("t1_hold", {19'd0, bb_left, bb_top, bb_right, bb_bottom, bb_empty},
            {19'd0, 11'd100, 11'd50, 11'd200, 11'd150, 1'b0});
        idx = mark;
        while (idx < rd_adr.size() && rd_adr[idx] != 3'd1) idx++;
        chk("t1_msg_read_seen", 64'(idx < rd_adr.size()), 64'd1);
        if (idx < rd_adr.size()) chk("t1_latency", 64'(last_valid_cyc - rd_cyc[idx]), 64'd7);
        check_counts("t1");

        // Two words buffered: polls only
        vmark = n_valid;
        fifo.push_back(32'h1111_1111);
        fifo.push_back(32'h2222_2222);
        mark = rd_adr.size();
        repeat (5 * (POLL_GAP + 2)) @(negedge clk);
        np = 0;
        nmsg = 0;
        last = -1;
        for (int i = mark; i < rd_adr.size(); i++) begin
            if (rd_adr[i] == 3'd0) begin
                if (last >= 0) chk("t2_poll_spacing", 64'(rd_cyc[i] - last), 64'(POLL_GAP + 2));
                last = rd_cyc[i];
                np++;
            end else begin
                nmsg++;
            end
        end
        chk("t2_polls", 64'(np >= 4), 64'd1);
        chk("t2_no_msg_read", 64'(nmsg), 64'd0);
        chk("t2_no_valid", 64'(n_valid), 64'(vmark));
        fifo.delete();
        repeat (POLL_GAP + 4) @(negedge clk);

        // Bad ID -> flush
        mark = n_wr;
        vmark = n_valid;
        push_msg(32'h0000_1234, 32'h0064_0032, 32'h00C8_0096);
        wait_drain("t3");
        chk("t3_one_write", 64'(n_wr), 64'(mark + 1));
        chk("t3_no_valid", 64'(n_valid), 64'(vmark));
        check_counts("t3");
        idx = 0;
        while (idx < rd_cyc.size() && rd_cyc[idx] <= last_wr_cyc) idx++;
        chk("t3_poll_after", 64'(idx < rd_cyc.size()), 64'd1);
        if (idx < rd_cyc.size()) begin
            chk("t3_poll_gap", 64'((rd_cyc[idx] - last_wr_cyc) >= POLL_GAP &&
                                   (rd_cyc[idx] - last_wr_cyc) <= POLL_GAP + 2), 64'd1);
        end

        // Empty box at the right edge
        push_msg(RBB, 32'h027F_01DF, 32'h0000_0000);
        wait_drain("t4");
        chk("t4_hold", {19'd0, bb_left, bb_top, bb_right, bb_bottom, bb_empty},
            {19'd0, 11'd639, 11'd479, 11'd0, 11'd0, 1'b1});
        check_counts("t4");

        // Enable dropped mid-message
        push_msg(RBB, 32'h0010_0020, 32'h0030_0040);
        wait_msg_reads(1, "t5");
        enable = 1'b0;
        wait_drain("t5");
        mark = rd_adr.size();
        repeat (3 * POLL_GAP) @(negedge clk);
        chk("t5_parked", 64'(rd_adr.size()), 64'(mark));
        check_counts("t5");
        enable = 1'b1;

        // Deep FIFO, status saturates at 255 words
        for (int i = 0; i < 86; i++) begin
            rand_msg(id, tl, br);
            push_msg(RBB, tl & 32'h07FF_07FF, {5'd0, 11'($urandom_range(0, IMAGE_W - 1)),
                                               5'd0, br[10:0]});
        end
        wait_drain("t6");
        check_counts("t6");

        // Random mix of good and corrupt messages
        for (int i = 0; i < 24; i++) begin
            rand_msg(id, tl, br);
            push_msg(id, tl, br);
            wait_drain("t7");
        end
        check_counts("t7");

        // err_count saturation
        for (int i = 0; i < 260; i++) begin
            push_msg(32'hDEAD_0000 ^ i, 32'h0, 32'h0);
            k = 0;
            while (fifo.size() != 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (k >= 200) chk("t8_flush_wait", 64'(k), 64'd0);
            repeat (2) @(negedge clk);
        end
        wait_drain("t8");
        check_counts("t8");
        chk("t8_sat", 64'(err_count), 64'd255);

        // Reset while waiting on the top-left word
        push_msg(RBB, 32'h0005_0006, 32'h0007_0008);
        wait_msg_reads(2, "t9");
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        exp_msg = 0;
        exp_err = 0;
        #1 check_all_zero("t9_reset");
        vmark = n_valid;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mark = rd_adr.size();
        k = 0;
        while (rd_adr.size() == mark && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t9_first_read", 64'(rd_adr.size() > mark), 64'd1);
        if (rd_adr.size() > mark) chk("t9_first_addr", 64'(rd_adr[mark]), 64'd0);
        repeat (3 * POLL_GAP) @(negedge clk);
        chk("t9_no_stale", 64'(n_valid), 64'(vmark));
        check_counts("t9");
        chk("t9_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
